// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic for an asynchronous FIFO.
// Keeps the binary/Gray write pointer and derives full, almost-full, fill level and overflow.
module fifo_wptr_full #(
    parameter int DLY        = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH:0]   rq2_wptr_i,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [ADDR_WIDTH:0]   wptr_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   wlevel_o,
    output logic                  overflow_o
);

    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AF_THRESH = AF_LEVEL[AW:0];

    // DLY only shapes register timing in behavioural simulation; this model applies no delay.
    if (DLY < 0) begin : g_dly_invalid
    end

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin;
    logic [AW:0] wlevel_next;
    logic        accept;

    assign accept      = wr_en_i & ~full_o;
    assign wbin_next   = wbin + {{AW{1'b0}}, accept};
    assign wgray_next  = wbin_next ^ (wbin_next >> 1);
    assign wlevel_next = wbin_next - rbin;
    assign waddr_o     = wbin[AW-1:0];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= AW; i++) begin : g_rbin
        assign rbin[i] = ^(rq2_wptr_i >> i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wbin          <= '0;
            wptr_o        <= '0;
            full_o        <= 1'b0;
            almost_full_o <= 1'b0;
            wlevel_o      <= '0;
            overflow_o    <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            wptr_o        <= wgray_next;
            // Full when the next write pointer is exactly one lap ahead of the read pointer.
            full_o        <= (wgray_next == {~rq2_wptr_i[AW:AW-1], rq2_wptr_i[AW-2:0]});
            almost_full_o <= (wlevel_next >= AF_THRESH);
            wlevel_o      <= wlevel_next;
            overflow_o    <= wr_en_i & full_o;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: a write/read counter model predicts every output cycle by cycle.
module tb_fifo_wptr_full;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       wr_en_i = 1'b0;
    logic [4:0] rq2_wptr_i = '0;
    logic [3:0] waddr_o;
    logic [4:0] wptr_o;
    logic       full_o;
    logic       almost_full_o;
    logic [4:0] wlevel_o;
    logic       overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: total accepted writes and total reads observed.
    int m_w = 0;
    int m_r = 0;
    bit m_full = 1'b0;
    bit m_ovf = 1'b0;

    always #5 clk_i = ~clk_i;

    fifo_wptr_full #(.DLY(1), .ADDR_WIDTH(4), .AF_LEVEL(12)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .wr_en_i(wr_en_i),
        .rq2_wptr_i(rq2_wptr_i),
        .waddr_o(waddr_o),
        .wptr_o(wptr_o),
        .full_o(full_o),
        .almost_full_o(almost_full_o),
        .wlevel_o(wlevel_o),
        .overflow_o(overflow_o)
    );

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    // Apply one cycle of stimulus, advance the model across the edge, settle 1 time unit later.
    task automatic drive_cycle(input bit wr, input int rnew);
        wr_en_i    = wr;
        rq2_wptr_i = to_gray(rnew);
        m_r        = rnew;
        @(posedge clk_i);
        m_ovf  = wr && m_full;
        if (wr && !m_full) m_w++;
        m_full = ((m_w - m_r) == 16);
        #1;
    endtask

    task automatic model_reset();
        m_w = 0; m_r = 0; m_full = 1'b0; m_ovf = 1'b0;
        wr_en_i = 1'b0; rq2_wptr_i = '0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (waddr_o !== 4'd0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", waddr_o); end
        n_cmp++; if (wptr_o !== 5'd0) begin n_err++; $display("FAIL reset_wptr: got %b want 00000", wptr_o); end
        n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full_o); end
        n_cmp++; if (almost_full_o !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b want 0", almost_full_o); end
        n_cmp++; if (wlevel_o !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", wlevel_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            drive_cycle(1'b1, 0);
            n_cmp++; if (waddr_o !== 4'(k % 16)) begin n_err++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", k, waddr_o, k % 16); end
            n_cmp++; if (almost_full_o !== (k >= 12)) begin n_err++; $display("FAIL fill_af[%0d]: got %b want %b", k, almost_full_o, k >= 12); end
            n_cmp++; if (full_o !== (k == 16)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", k, full_o, k == 16); end
            n_cmp++; if (wlevel_o !== 5'(k)) begin n_err++; $display("FAIL fill_level[%0d]: got %0d want %0d", k, wlevel_o, k); end
        end
        n_cmp++; if (wptr_o !== 5'b11000) begin n_err++; $display("FAIL fill_wptr: got %b want 11000", wptr_o); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 0);
            n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_pulse[%0d]: got %b want 1", k, overflow_o); end
            n_cmp++; if (wptr_o !== 5'b11000) begin n_err++; $display("FAIL ovf_wptr[%0d]: got %b want 11000", k, wptr_o); end
            n_cmp++; if (waddr_o !== 4'd0) begin n_err++; $display("FAIL ovf_waddr[%0d]: got %0d want 0", k, waddr_o); end
        end
        drive_cycle(1'b0, 0);
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow_o); end
        n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL ovf_still_full: got %b want 1", full_o); end
    endtask

    task automatic test_read_release();
        drive_cycle(1'b0, 1);
        n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL rel_full: got %b want 0", full_o); end
        n_cmp++; if (wlevel_o !== 5'd15) begin n_err++; $display("FAIL rel_level: got %0d want 15", wlevel_o); end
        n_cmp++; if (almost_full_o !== 1'b1) begin n_err++; $display("FAIL rel_af: got %b want 1", almost_full_o); end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b1, 2);
        n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL simul_full: got %b want 0", full_o); end
        n_cmp++; if (wlevel_o !== 5'd15) begin n_err++; $display("FAIL simul_level: got %0d want 15", wlevel_o); end
        n_cmp++; if (waddr_o !== 4'd1) begin n_err++; $display("FAIL simul_waddr: got %0d want 1", waddr_o); end
        n_cmp++; if (wptr_o !== to_gray(17)) begin n_err++; $display("FAIL simul_wptr: got %b want %b", wptr_o, to_gray(17)); end
    endtask

    task automatic test_wrap();
        int hist[$];
        logic [4:0] prev;
        test_reset();
        hist = '{0, 0};
        prev = wptr_o;
        for (int k = 0; k < 40; k++) begin
            drive_cycle(1'b1, hist[0]);
            hist.pop_front();
            hist.push_back(m_w);
            n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL wrap_full[%0d]: got %b want 0", k, full_o); end
            n_cmp++; if (wptr_o !== to_gray(m_w)) begin n_err++; $display("FAIL wrap_wptr[%0d]: got %b want %b", k, wptr_o, to_gray(m_w)); end
            n_cmp++; if (waddr_o !== 4'(m_w % 16)) begin n_err++; $display("FAIL wrap_waddr[%0d]: got %0d want %0d", k, waddr_o, m_w % 16); end
            n_cmp++; if ($countones(prev ^ wptr_o) > 1) begin n_err++; $display("FAIL wrap_gray_step[%0d]: got %b after %b want one bit change", k, wptr_o, prev); end
            prev = wptr_o;
        end
    endtask

    task automatic test_random();
        logic [4:0] prev;
        int rnew;
        bit wr;
        test_reset();
        prev = wptr_o;
        for (int k = 0; k < 400; k++) begin
            wr   = ($urandom_range(0, 3) != 0);
            rnew = m_r;
            if (m_w > m_r) rnew = m_r + $urandom_range(0, (k % 100 < 50) ? 1 : 3) % (m_w - m_r + 1);
            drive_cycle(wr, rnew);
            n_cmp++; if (waddr_o !== 4'(m_w % 16)) begin n_err++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", k, waddr_o, m_w % 16); end
            n_cmp++; if (wptr_o !== to_gray(m_w)) begin n_err++; $display("FAIL rnd_wptr[%0d]: got %b want %b", k, wptr_o, to_gray(m_w)); end
            n_cmp++; if (full_o !== m_full) begin n_err++; $display("FAIL rnd_full[%0d]: got %b want %b", k, full_o, m_full); end
            n_cmp++; if (wlevel_o !== 5'(m_w - m_r)) begin n_err++; $display("FAIL rnd_level[%0d]: got %0d want %0d", k, wlevel_o, m_w - m_r); end
            n_cmp++; if (almost_full_o !== ((m_w - m_r) >= 12)) begin n_err++; $display("FAIL rnd_af[%0d]: got %b want %b", k, almost_full_o, (m_w - m_r) >= 12); end
            n_cmp++; if (overflow_o !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d]: got %b want %b", k, overflow_o, m_ovf); end
            n_cmp++; if ($countones(prev ^ wptr_o) > 1) begin n_err++; $display("FAIL rnd_gray_step[%0d]: got %b after %b", k, wptr_o, prev); end
            prev = wptr_o;
        end
    endtask

    task automatic test_async_reset();
        test_reset();
        for (int k = 0; k < 9; k++) drive_cycle(1'b1, 0);
        n_cmp++; if (wlevel_o !== 5'd9) begin n_err++; $display("FAIL arst_pre_level: got %0d want 9", wlevel_o); end
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        n_cmp++; if (waddr_o !== 4'd0) begin n_err++; $display("FAIL arst_waddr: got %0d want 0", waddr_o); end
        n_cmp++; if (wptr_o !== 5'd0) begin n_err++; $display("FAIL arst_wptr: got %b want 00000", wptr_o); end
        n_cmp++; if (wlevel_o !== 5'd0) begin n_err++; $display("FAIL arst_level: got %0d want 0", wlevel_o); end
        n_cmp++; if (full_o !== 1'b0 || almost_full_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_err++; $display("FAIL arst_flags: got full=%b af=%b ovf=%b want 0 0 0", full_o, almost_full_o, overflow_o);
        end
        model_reset();
        wr_en_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_cmp++; if (waddr_o !== 4'd0) begin n_err++; $display("FAIL arst_hold_waddr: got %0d want 0", waddr_o); end
        rst_i = 1'b0;
        drive_cycle(1'b1, 0);
        n_cmp++; if (waddr_o !== 4'd1) begin n_err++; $display("FAIL arst_resume_waddr: got %0d want 1", waddr_o); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_simultaneous();
        test_wrap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 SHALL have parameter DLY, default 1, the simulation-only delay applied to every register assignment.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, giving FIFO depth 2^ADDR_WIDTH.
REQ-003 SHALL have parameter AF_LEVEL, default 12, the fill level at or above which almost_full_o asserts (legal 1..2^ADDR_WIDTH).
REQ-004 SHALL have port clk_i, input, 1, the write-domain clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; it is asynchronous and active-high.
REQ-006 SHALL have port wr_en_i, input, 1, write request.
REQ-007 SHALL have port rq2_wptr_i, input, ADDR_WIDTH+1, the read pointer in Gray code, already synchronised into clk_i.
REQ-008 SHALL have port waddr_o, output, ADDR_WIDTH, the RAM write address.
REQ-009 SHALL have port wptr_o, output, ADDR_WIDTH+1, the registered Gray write pointer sent to the read-domain synchroniser.
REQ-010 SHALL have port full_o, output, 1, the FIFO-full flag.
REQ-011 SHALL have port almost_full_o, output, 1, the fill-level threshold flag.
REQ-012 SHALL have port wlevel_o, output, ADDR_WIDTH+1, the write-side fill level (0..2^ADDR_WIDTH).
REQ-013 SHALL have port overflow_o, output, 1, a one-cycle pulse on a rejected write.

Function
REQ-014 SHALL hold a binary write pointer wbin of ADDR_WIDTH+1 bits and drive waddr_o = wbin[ADDR_WIDTH-1:0].
REQ-015 SHALL accept a write when wr_en_i=1 and full_o=0; wbin_next = wbin+1 on accept, otherwise wbin_next = wbin.
REQ-016 SHALL wrap wbin modulo 2^(ADDR_WIDTH+1) with no saturation; the MSB toggles once per full lap.
REQ-017 SHALL compute wgray_next = wbin_next ^ (wbin_next >> 1) and register it into wptr_o on the same edge that updates wbin.
REQ-018 SHALL register full_o from wgray_next == {~rq2_wptr_i[AW:AW-1], rq2_wptr_i[AW-2:0]} (AW = ADDR_WIDTH), so full asserts on the edge of the filling write, with zero cycles of latency.
REQ-019 SHALL convert rq2_wptr_i to binary rbin combinationally: rbin[AW] = g[AW]; rbin[i] = rbin[i+1] ^ g[i].
REQ-020 SHALL register wlevel_o = (wbin_next - rbin) mod 2^(AW+1).
REQ-021 SHALL register almost_full_o = (wlevel_next >= AF_LEVEL).
REQ-022 SHALL pulse overflow_o high for exactly one cycle when wr_en_i=1 and full_o=1; in that case wbin, wptr_o and waddr_o shall not change.
REQ-023 SHALL deassert full_o on the first edge after rq2_wptr_i advances, with no write required.
REQ-024 SHALL, on a simultaneous accepted write and read-pointer advance, evaluate full_o and wlevel_o against both new values; the level is unchanged.
REQ-025 SHALL change at most one bit of wptr_o per clock.

Reset
REQ-026 SHALL, while rst_i=1, asynchronously force wbin=0, waddr_o=0, wptr_o=0, full_o=0, almost_full_o=0, wlevel_o=0 and overflow_o=0, regardless of clk_i.
REQ-027 SHALL ignore wr_en_i on the first edge after rst_i falls only if rst_i was still high at that edge; otherwise it shall operate normally.
REQ-028 SHALL, on reset mid-operation, discard all pointer state; the read side must be reset in the same window.

Verification (ADDR_WIDTH=4, AF_LEVEL=12)
REQ-029 SHALL cover the following: with reset released and rq2=0, 16 consecutive writes -> waddr_o 0..15 then 0; wptr_o ends at 5'b11000; full_o rises on the 16th edge; almost_full_o rises on the 12th edge; wlevel_o=16.
REQ-030 SHALL cover the following: from full, with wr_en_i held for 3 cycles -> overflow_o pulses high for 3 cycles; wptr_o stays 5'b11000; waddr_o stays 0.
REQ-031 SHALL cover the following: from full, with rq2_wptr_i driven to 5'b00001 (rbin=1) and no write -> next edge gives full_o=0, wlevel_o=15, almost_full_o=1.
REQ-032 SHALL cover the following: with level 15 and a write on the same edge that rq2 advances by one -> full_o=0, wlevel_o=15, waddr_o increments.
REQ-033 SHALL cover the following: 40 writes with rq2 tracking wptr_o two cycles late -> wbin wraps past 31 to 0; full_o is never set; Gray outputs change one bit per cycle.
REQ-034 SHALL cover the following: rst_i asserted asynchronously mid-cycle at level 9 -> all outputs are 0 before the next clk_i edge.
